blob_bounding_box: RTL

Consumes the per-pixel thresholded stream from the camera's colour-threshold stage and measures the detected blob in each frame. It tracks the pixel position within the frame, counts detected pixels, and records the minimum/maximum column and row of detected pixels. At each frame boundary it commits the result to stable output registers and pulses a valid strobe for the CPU-side register interface.

---
 rtl/blob_bounding_box.sv | 105 ++++++++++
 1 files changed

// File: rtl/blob_bounding_box.sv
// blob_bounding_box: per-frame detected-pixel count and bounding box of a thresholded pixel stream
// Ports:
//   clock, nReset              - rising-edge clock, asynchronous active-low reset
//   newScreen, newLine         - one-cycle start-of-frame / end-of-line pulses
//   pixelValid, thresholdedPixel - pixel stream; 16'h07E0 marks a detected pixel
//   resultValid                - one-cycle pulse when the result registers update
//   found, minX, maxX, minY, maxY, pixelCount - committed result of the last frame
module blob_bounding_box #(
    parameter int X_BITS     = 11,
    parameter int Y_BITS     = 10,
    parameter int COUNT_BITS = 20,
    parameter int MIN_PIXELS = 16
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  newScreen,
    input  logic                  newLine,
    input  logic                  pixelValid,
    input  logic [15:0]           thresholdedPixel,
    output logic                  resultValid,
    output logic                  found,
    output logic [X_BITS-1:0]     minX,
    output logic [X_BITS-1:0]     maxX,
    output logic [Y_BITS-1:0]     minY,
    output logic [Y_BITS-1:0]     maxY,
    output logic [COUNT_BITS-1:0] pixelCount
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;
    logic commit, run;
    logic [X_BITS-1:0] x, xb, x_nxt, accMinX, accMaxX, mnxb, mxxb, mnx_nxt, mxx_nxt;
    logic [Y_BITS-1:0] y, yb, accMinY, accMaxY, mnyb, mxyb, mny_nxt, mxy_nxt;
    logic [COUNT_BITS-1:0] accCount, cb, cnt_nxt;
    logic hit;

    always_ff @(posedge clock or negedge nReset)
        if (!nReset) state <= IDLE;
        else state <= state_nxt;

    always_comb state_nxt = newScreen ? ACTIVE : state;

    always_comb begin
        commit = newScreen && state == ACTIVE;
        run    = newScreen || state == ACTIVE;
    end

    // Control events are applied first; the pixel then lands on the updated position/accumulators.
    always_comb begin
        hit     = pixelValid && thresholdedPixel == 16'h07E0;
        xb      = (newScreen || newLine) ? '0 : x;
        yb      = newScreen ? '0 : newLine ? (&y ? y : y + 1'b1) : y;
        cb      = newScreen ? '0 : accCount;
        mnxb    = newScreen ? '1 : accMinX;
        mxxb    = newScreen ? '0 : accMaxX;
        mnyb    = newScreen ? '1 : accMinY;
        mxyb    = newScreen ? '0 : accMaxY;
        x_nxt   = (pixelValid && !(&xb)) ? xb + 1'b1 : xb;
        cnt_nxt = (hit && !(&cb)) ? cb + 1'b1 : cb;
        mnx_nxt = (hit && xb < mnxb) ? xb : mnxb;
        mxx_nxt = (hit && xb > mxxb) ? xb : mxxb;
        mny_nxt = (hit && yb < mnyb) ? yb : mnyb;
        mxy_nxt = (hit && yb > mxyb) ? yb : mxyb;
    end

    always_ff @(posedge clock or negedge nReset)
        if (!nReset) begin
            x        <= '0;
            y        <= '0;
            accCount <= '0;
            accMinX  <= '1;
            accMaxX  <= '0;
            accMinY  <= '1;
            accMaxY  <= '0;
        end else if (run) begin
            x        <= x_nxt;
            y        <= yb;
            accCount <= cnt_nxt;
            accMinX  <= mnx_nxt;
            accMaxX  <= mxx_nxt;
            accMinY  <= mny_nxt;
            accMaxY  <= mxy_nxt;
        end

    // An empty frame reports zero bounds rather than the all-ones/zero accumulator seeds.
    always_ff @(posedge clock or negedge nReset)
        if (!nReset) begin
            resultValid <= 1'b0;
            found       <= 1'b0;
            minX        <= '0;
            maxX        <= '0;
            minY        <= '0;
            maxY        <= '0;
            pixelCount  <= '0;
        end else begin
            resultValid <= commit;
            if (commit) begin
                pixelCount <= accCount;
                found      <= accCount >= COUNT_BITS'(MIN_PIXELS);
                minX       <= accCount == '0 ? '0 : accMinX;
                maxX       <= accCount == '0 ? '0 : accMaxX;
                minY       <= accCount == '0 ? '0 : accMinY;
                maxY       <= accCount == '0 ? '0 : accMaxY;
            end
        end
endmodule
